// File: rtl/store_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// store_pkg : funct3 store encodings, FSM state type, lane count
// Rev 1.0
// ------------------------------------------------------------------
package store_pkg;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  localparam int unsigned LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/store_lane_shift.sv
`default_nettype none
// ------------------------------------------------------------------
// store_lane_shift : positions store data and byte mask over 8 lanes
// Rev 1.0
// ------------------------------------------------------------------
module store_lane_shift
  import store_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] data_i,
  output logic [63:0] data_o,
  output logic [7:0]  mask_o,
  output logic        legal_o
);

  logic [3:0]  base_mask;
  logic [63:0] shifted;

  always_comb begin
    base_mask = 4'b0000;
    legal_o   = 1'b1;
    case (funct3_i)
      SB:      base_mask = 4'b0001;
      SH:      base_mask = 4'b0011;
      SW:      base_mask = 4'b1111;
      default: legal_o   = 1'b0;
    endcase
    mask_o  = {4'b0000, base_mask} << off_i;
    shifted = {32'h0, data_i} << {off_i, 3'b000};
  end

  // Disabled lanes carry zero so stale high bytes of rs2 never reach memory.
  for (genvar i = 0; i < 2 * LANES; i++) begin : g_lane
    assign data_o[8*i +: 8] = shifted[8*i +: 8] & {8{mask_o[i]}};
  end

endmodule
`default_nettype wire

// File: rtl/store_align_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// store_align_unit : turns byte/half/word stores into 1-2 aligned beats
// Rev 1.0
// ------------------------------------------------------------------
module store_align_unit
  import store_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  output logic        done_o,
  output logic        err_o,
  output logic        busy_o
);

  state_t      state_q,     state_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] addr_q,      addr_d;
  logic [31:0] wdata_q,     wdata_d;
  logic [3:0]  be_q,        be_d;
  logic [31:0] hi_wdata_q,  hi_wdata_d;
  logic [3:0]  hi_be_q,     hi_be_d;

  logic [63:0] sh_data;
  logic [7:0]  sh_mask;
  logic        sh_legal;
  logic        accept;
  logic        crossing;

  store_lane_shift u_shift (
    .funct3_i (funct3_i),
    .off_i    (addr_i[1:0]),
    .data_i   (data_i),
    .data_o   (sh_data),
    .mask_o   (sh_mask),
    .legal_o  (sh_legal)
  );

  assign req_ready_o = (state_q == ST_IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign crossing    = (sh_mask[7:4] != 4'b0000);

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    hi_wdata_d  = hi_wdata_q;
    hi_be_d     = hi_be_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!sh_legal || (crossing && !ALLOW_MISALIGNED)) begin
            state_d = ST_ERR;
          end else begin
            state_d     = ST_BEAT0;
            mem_valid_d = 1'b1;
            addr_d      = {addr_i[31:2], 2'b00};
            wdata_d     = sh_data[31:0];
            be_d        = sh_mask[3:0];
            hi_wdata_d  = sh_data[63:32];
            hi_be_d     = sh_mask[7:4];
          end
        end
      end
      ST_BEAT0: begin
        if (mem_ready_i) begin
          if (hi_be_q != 4'b0000) begin
            // Wraps naturally at the top of the address space.
            state_d = ST_BEAT1;
            addr_d  = addr_q + 32'd4;
            wdata_d = hi_wdata_q;
            be_d    = hi_be_q;
          end else begin
            state_d     = ST_IDLE;
            mem_valid_d = 1'b0;
          end
        end
      end
      ST_BEAT1: begin
        if (mem_ready_i) begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      hi_wdata_q  <= 32'h0;
      hi_be_q     <= 4'h0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      hi_wdata_q  <= hi_wdata_d;
      hi_be_q     <= hi_be_d;
    end
  end

  assign mem_valid_o = mem_valid_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign err_o       = (state_q == ST_ERR);
  assign done_o      = mem_valid_q && mem_ready_i &&
                       ((state_q == ST_BEAT1) ||
                        ((state_q == ST_BEAT0) && (hi_be_q == 4'b0000)));

endmodule
`default_nettype wire

// File: tb/tb_store_align_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_store_align_unit : directed self-checking bench for store_align_unit
// Rev 1.0
// ------------------------------------------------------------------
module tb_store_align_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_valid_nm = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] data = 32'h0;
  logic        mem_ready = 1'b1;

  logic        req_ready, mem_valid, done, err, busy;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        req_ready_nm, mem_valid_nm, done_nm, err_nm, busy_nm;
  logic [31:0] mem_addr_nm, mem_wdata_nm;
  logic [3:0]  mem_be_nm;

  int checks = 0;
  int failures = 0;

  // {valid, done, err, be, addr, wdata}
  logic [70:0] obs, obs_nm;
  assign obs    = {mem_valid, done, err, mem_be, mem_addr, mem_wdata};
  assign obs_nm = {mem_valid_nm, done_nm, err_nm, mem_be_nm, mem_addr_nm, mem_wdata_nm};

  always #5 clk = ~clk;

  store_align_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .funct3_i(funct3), .addr_i(addr), .data_i(data), .mem_valid_o(mem_valid),
    .mem_ready_i(mem_ready), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_be_o(mem_be), .done_o(done), .err_o(err), .busy_o(busy)
  );

  store_align_unit #(.ALLOW_MISALIGNED(1'b0)) dut_nm (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid_nm), .req_ready_o(req_ready_nm),
    .funct3_i(funct3), .addr_i(addr), .data_i(data), .mem_valid_o(mem_valid_nm),
    .mem_ready_i(mem_ready), .mem_addr_o(mem_addr_nm), .mem_wdata_o(mem_wdata_nm),
    .mem_be_o(mem_be_nm), .done_o(done_nm), .err_o(err_nm), .busy_o(busy_nm)
  );

  // Presents one request for one clock; returns 1 ns after the following negedge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       input logic to_nm);
    @(negedge clk);
    funct3 = f3; addr = a; data = d;
    if (to_nm) req_valid_nm = 1'b1; else req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_valid_nm = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({obs, busy, req_ready} !== {71'h0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL reset_state: got %h/%b/%b exp 0/0/1", obs, busy, req_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if ({mem_valid, busy, req_ready} !== 3'b001) begin
      failures++; $display("FAIL reset_release: got %b exp 001", {mem_valid, busy, req_ready});
    end
  endtask

  task automatic test_sw_aligned;
    mem_ready = 1'b1;
    issue(3'b010, 32'h100, 32'hDEADBEEF, 1'b0);
    checks++;
    if ({obs, req_ready, busy} !== {1'b1, 1'b1, 1'b0, 4'hF, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1}) begin
      failures++; $display("FAIL sw_beat: got %h exp %h", obs, {1'b1, 1'b1, 1'b0, 4'hF, 32'h100, 32'hDEADBEEF});
    end
    @(negedge clk); #1;
    checks++;
    if ({mem_valid, done, req_ready, busy} !== 4'b0010) begin
      failures++; $display("FAIL sw_after: got %b exp 0010", {mem_valid, done, req_ready, busy});
    end
  endtask

  task automatic test_sb_lane3;
    issue(3'b000, 32'h103, 32'h000000A5, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b1, 1'b0, 4'b1000, 32'h100, 32'hA5000000}) begin
      failures++; $display("FAIL sb_beat: got %h exp %h", obs, {1'b1, 1'b1, 1'b0, 4'b1000, 32'h100, 32'hA5000000});
    end
    @(negedge clk); #1;
  endtask

  task automatic test_sh_split;
    issue(3'b001, 32'h203, 32'h00001234, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 4'b1000, 32'h200, 32'h34000000}) begin
      failures++; $display("FAIL sh_beat0: got %h exp %h", obs, {1'b1, 1'b0, 1'b0, 4'b1000, 32'h200, 32'h34000000});
    end
    @(negedge clk); #1;
    checks++;
    if (obs !== {1'b1, 1'b1, 1'b0, 4'b0001, 32'h204, 32'h00000012}) begin
      failures++; $display("FAIL sh_beat1: got %h exp %h", obs, {1'b1, 1'b1, 1'b0, 4'b0001, 32'h204, 32'h00000012});
    end
    @(negedge clk); #1;
    checks++;
    if ({mem_valid, done, req_ready} !== 3'b001) begin
      failures++; $display("FAIL sh_after: got %b exp 001", {mem_valid, done, req_ready});
    end
  endtask

  task automatic test_sw_stall;
    @(negedge clk); mem_ready = 1'b0;
    funct3 = 3'b010; addr = 32'h101; data = 32'h11223344; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({obs, req_ready} !== {1'b1, 1'b0, 1'b0, 4'b1110, 32'h100, 32'h22334400, 1'b0}) begin
        failures++; $display("FAIL stall_hold%0d: got %h exp %h", i, obs, {1'b1, 1'b0, 1'b0, 4'b1110, 32'h100, 32'h22334400});
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 4'b1110, 32'h100, 32'h22334400}) begin
      failures++; $display("FAIL stall_beat0: got %h exp %h", obs, {1'b1, 1'b0, 1'b0, 4'b1110, 32'h100, 32'h22334400});
    end
    @(negedge clk); #1;
    checks++;
    if (obs !== {1'b1, 1'b1, 1'b0, 4'b0001, 32'h104, 32'h00000011}) begin
      failures++; $display("FAIL stall_beat1: got %h exp %h", obs, {1'b1, 1'b1, 1'b0, 4'b0001, 32'h104, 32'h00000011});
    end
    @(negedge clk); #1;
  endtask

  task automatic test_addr_wrap;
    issue(3'b001, 32'hFFFFFFFF, 32'h0000ABCD, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 4'b1000, 32'hFFFFFFFC, 32'hCD000000}) begin
      failures++; $display("FAIL wrap_beat0: got %h exp %h", obs, {1'b1, 1'b0, 1'b0, 4'b1000, 32'hFFFFFFFC, 32'hCD000000});
    end
    @(negedge clk); #1;
    checks++;
    if (obs !== {1'b1, 1'b1, 1'b0, 4'b0001, 32'h0, 32'h000000AB}) begin
      failures++; $display("FAIL wrap_beat1: got %h exp %h", obs, {1'b1, 1'b1, 1'b0, 4'b0001, 32'h0, 32'h000000AB});
    end
    @(negedge clk); #1;
  endtask

  task automatic test_errors;
    issue(3'b011, 32'h100, 32'h12345678, 1'b0);
    checks++;
    if ({mem_valid, err, done, req_ready, busy} !== 5'b01001) begin
      failures++; $display("FAIL badf3_err: got %b exp 01001", {mem_valid, err, done, req_ready, busy});
    end
    @(negedge clk); #1;
    checks++;
    if ({mem_valid, err, req_ready, busy} !== 4'b0010) begin
      failures++; $display("FAIL badf3_after: got %b exp 0010", {mem_valid, err, req_ready, busy});
    end
    issue(3'b001, 32'h3, 32'h00005678, 1'b1);
    checks++;
    if ({mem_valid_nm, err_nm, req_ready_nm, busy_nm} !== 4'b0101) begin
      failures++; $display("FAIL nm_cross_err: got %b exp 0101", {mem_valid_nm, err_nm, req_ready_nm, busy_nm});
    end
    @(negedge clk); #1;
    checks++;
    if ({mem_valid_nm, err_nm, req_ready_nm, busy_nm} !== 4'b0010) begin
      failures++; $display("FAIL nm_cross_after: got %b exp 0010", {mem_valid_nm, err_nm, req_ready_nm, busy_nm});
    end
    // Halfword at offset 2 stays within one word, so it is legal without splitting.
    issue(3'b001, 32'h2, 32'hFFFF5678, 1'b1);
    checks++;
    if (obs_nm !== {1'b1, 1'b1, 1'b0, 4'b1100, 32'h0, 32'h56780000}) begin
      failures++; $display("FAIL nm_sh_off2: got %h exp %h", obs_nm, {1'b1, 1'b1, 1'b0, 4'b1100, 32'h0, 32'h56780000});
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset_mid;
    mem_ready = 1'b1;
    issue(3'b001, 32'h203, 32'h00001234, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 4'b0001, 32'h204, 32'h00000012}) begin
      failures++; $display("FAIL rst_pre_beat1: got %h exp %h", obs, {1'b1, 1'b0, 1'b0, 4'b0001, 32'h204, 32'h00000012});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({obs, busy} !== 72'h0) begin
      failures++; $display("FAIL rst_async: got %h/%b exp 0/0", obs, busy);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    checks++;
    if ({mem_valid, busy, req_ready, done} !== 4'b0010) begin
      failures++; $display("FAIL rst_release: got %b exp 0010", {mem_valid, busy, req_ready, done});
    end
    @(negedge clk); #1;
    checks++;
    if ({mem_valid, done, req_ready} !== 3'b001) begin
      failures++; $display("FAIL rst_no_beat1: got %b exp 001", {mem_valid, done, req_ready});
    end
  endtask

  initial begin
    test_reset();
    test_sw_aligned();
    test_sb_lane3();
    test_sh_split();
    test_sw_stall();
    test_addr_wrap();
    test_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/store_align_unit.md
STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

Interface
REQ-001 Parameter ALLOW_MISALIGNED, default 1: 1 = split word-crossing stores into two beats; 0 = flag them as errors.
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-004 req_valid_i  in  1  store request valid.
REQ-005 req_ready_o  out  1  unit can accept a request.
REQ-006 funct3_i  in  3  store width: 000 sb, 001 sh, 010 sw.
REQ-007 addr_i  in  32  byte address.
REQ-008 data_i  in  32  store data, right-justified (rs2).
REQ-009 mem_valid_o  out  1  memory write beat valid.
REQ-010 mem_ready_i  in  1  memory accepts beat.
REQ-011 mem_addr_o  out  32  word-aligned beat address, bits [1:0] = 00.
REQ-012 mem_wdata_o  out  32  lane-positioned write data.
REQ-013 mem_be_o  out  4  byte enables, bit n = byte lane n.
REQ-014 done_o  out  1  one-cycle pulse when the last beat is accepted.
REQ-015 err_o  out  1  one-cycle pulse on a rejected request.
REQ-016 busy_o  out  1  high whenever state is not IDLE.

Function
REQ-017 States are IDLE, BEAT0, BEAT1 and ERR; req_ready_o SHALL be 1 only in IDLE.
REQ-018 A request is accepted when req_valid_i && req_ready_o; funct3, addr and data are latched on acceptance.
REQ-019 Base mask SHALL be 0001 for sb, 0011 for sh and 1111 for sw; off = addr[1:0].
REQ-020 An 8-lane mask is mask<<off and 64-bit data is data<<(8*off); beat0 uses lanes 3:0 and beat1 uses lanes 7:4.
REQ-021 Bytes in lanes with be=0 SHALL be driven 0.
REQ-022 A legal request whose mask lanes 7:4 are all zero SHALL go IDLE->BEAT0; a beat0 handshake then pulses done_o and returns the unit to IDLE.
REQ-023 A legal request whose mask lanes 7:4 are non-zero, with ALLOW_MISALIGNED=1, SHALL go IDLE->BEAT0; the beat0 handshake moves it to BEAT1, and the BEAT1 handshake pulses done_o and returns it to IDLE.
REQ-024 The beat0 address is {addr[31:2],2'b00}; the beat1 address is the beat0 address + 4, wrapping 0xFFFFFFFC -> 0x00000000.
REQ-025 An illegal funct3, or a word-crossing request with ALLOW_MISALIGNED=0, SHALL go IDLE->ERR; ERR pulses err_o for one cycle, issues no beat, and returns to IDLE.
REQ-026 mem_valid_o SHALL be registered: it is high in BEAT0/BEAT1 starting the cycle after acceptance; addr, wdata and be are held stable while mem_valid_o && !mem_ready_i.
REQ-027 Latency: aligned store accepted in cycle N with mem_ready_i=1 -> beat in N+1, done_o in N+1, req_ready_o in N+2; a split store adds one cycle per beat.
REQ-028 mem_ready_i is ignored while mem_valid_o=0.

Reset
REQ-029 rst_n_i low SHALL immediately force state IDLE and drive mem_valid_o, done_o, err_o, busy_o, mem_addr_o, mem_wdata_o and mem_be_o to 0.
REQ-030 Reset mid-transfer (BEAT0/BEAT1) SHALL abandon the store with no further beats; req_ready_o=1 in the first cycle after release.

Structure
REQ-031 Package store_pkg SHALL hold the funct3 encodings (SB, SH, SW), the state enum and the lane count constant (4).
REQ-032 Combinational sub-module store_lane_shift SHALL compute the 64-bit shifted data and the 8-bit mask from funct3, off and data; the FSM and registers stay in store_align_unit.

Verification
REQ-033 sw addr 0x100 data 0xDEADBEEF, mem_ready_i=1 -> one beat: addr 0x100, be 1111, wdata 0xDEADBEEF; done_o pulse; err_o 0.
REQ-034 sb addr 0x103 data 0x000000A5 -> one beat: addr 0x100, be 1000, wdata 0xA5000000.
REQ-035 sh addr 0x203 data 0x00001234, ALLOW_MISALIGNED=1 -> beat0: addr 0x200, be 1000, wdata 0x34000000; beat1: addr 0x204, be 0001, wdata 0x00000012; a single done_o.
REQ-036 sw addr 0x101 data 0x11223344, mem_ready_i low for 3 cycles -> beat0 (addr 0x100, be 1110, wdata 0x22334400) held stable for 3 cycles, then beat1 (addr 0x104, be 0001, wdata 0x00000011).
REQ-037 funct3=011, and separately sh addr 0x3 with ALLOW_MISALIGNED=0 -> err_o one-cycle pulse, mem_valid_o never high, req_ready_o back to 1 two cycles after acceptance.
REQ-038 rst_n_i pulsed low during BEAT1 of the REQ-035 store -> all outputs 0 asynchronously, no beat1 handshake, req_ready_o=1 after release.
